tw_rom_writer: RTL and testbench

- Generates the twiddle table for one NTT stage at runtime and writes it into the twiddle RAM that the stage's twiddle read path consumes.
- Computes successive powers root^k mod q with a latency-modelled modular multiplier.
- Writes each entry through a valid/ready write port.
- Uses a start/busy/done handshake so the top-level controller can reload twiddles when q or root changes.

---
 rtl/tw_rom_writer.sv | 111 +++++++++++
 tb/tb_tw_rom_writer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tw_rom_writer.sv
// Twiddle table generator for one NTT stage: writes root^k mod q, k = 0..NUM-1,
// into the twiddle RAM through a valid/ready port, with a start/busy/done handshake.
module tw_rom_writer #(
  parameter int LOGQ      = 14,
  parameter int LOGN      = 10,
  parameter int DELAY_MUL = 3,
  parameter int STAGE     = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [LOGQ-1:0] q,
  input  logic [LOGQ-1:0] root,
  output logic            wen,
  output logic [LOGN-1:0] waddr,
  output logic [LOGQ-1:0] wdata,
  input  logic            wready,
  output logic            busy,
  output logic            done
);

  localparam int NUM = (STAGE == 0) ? 1 : (1 << (STAGE - 1));
  localparam int CW  = (DELAY_MUL > 1) ? $clog2(DELAY_MUL) : 1;
  localparam logic [LOGN-1:0] LAST_ADDR = LOGN'(NUM - 1);
  localparam logic [CW-1:0]   CNT_LOAD  = CW'(DELAY_MUL - 1);

  typedef enum logic [1:0] {IDLE, WR, MUL, DONE} state_t;

  state_t          state;
  logic [LOGQ-1:0] q_r;
  logic [LOGQ-1:0] root_r;
  logic [LOGQ-1:0] acc;
  logic [LOGQ-1:0] prod_r;
  logic [LOGN-1:0] addr;
  logic [CW-1:0]   cnt;

  logic [2*LOGQ-1:0] prod_full;
  logic [2*LOGQ-1:0] q_ext;

  always_comb begin
    prod_full = {{LOGQ{1'b0}}, acc} * {{LOGQ{1'b0}}, root_r};
    q_ext     = {{LOGQ{1'b0}}, q_r};
  end

  // The product is captured at launch and only committed to acc after
  // DELAY_MUL cycles in MUL, which models the multiplier pipeline latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      q_r    <= '0;
      root_r <= '0;
      acc    <= '0;
      prod_r <= '0;
      addr   <= '0;
      cnt    <= '0;
      wen    <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q_r    <= q;
            root_r <= (q == '0) ? root : (root % q);
            acc    <= LOGQ'(1);
            addr   <= '0;
            wen    <= 1'b1;
            waddr  <= '0;
            wdata  <= LOGQ'(1);
            busy   <= 1'b1;
            state  <= WR;
          end
        end
        WR: begin
          if (wready) begin
            wen <= 1'b0;
            if (addr == LAST_ADDR) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              prod_r <= (q_r == '0) ? prod_full[LOGQ-1:0] : LOGQ'(prod_full % q_ext);
              cnt    <= CNT_LOAD;
              state  <= MUL;
            end
          end
        end
        MUL: begin
          if (cnt == '0) begin
            acc   <= prod_r;
            addr  <= addr + LOGN'(1);
            wen   <= 1'b1;
            waddr <= addr + LOGN'(1);
            wdata <= prod_r;
            state <= WR;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tw_rom_writer.sv
// Directed self-checking bench for tw_rom_writer: STAGE 3, 4 and 0 instances
// with hand-computed twiddle tables for q=7681.
module tb_tw_rom_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] q = 14'd7681;
  logic [13:0] root = 14'd17;

  logic        start3 = 1'b0, wr3 = 1'b1, wen3, busy3, done3;
  logic [9:0]  waddr3;
  logic [13:0] wdata3;
  logic        start4 = 1'b0, wr4 = 1'b1, wen4, busy4, done4;
  logic [9:0]  waddr4;
  logic [13:0] wdata4;
  logic        start0 = 1'b0, wr0 = 1'b1, wen0, busy0, done0;
  logic [9:0]  waddr0;
  logic [13:0] wdata0;

  int n_checks = 0;
  int n_fail   = 0;

  // 17^k mod 7681, k = 0..7
  logic [13:0] tbl17 [0:7] = '{14'd1, 14'd17, 14'd289, 14'd4913,
                               14'd6711, 14'd6553, 14'd3867, 14'd4291};
  logic [13:0] tbl3  [0:3] = '{14'd1, 14'd3, 14'd9, 14'd27};
  logic [13:0] tbl19 [0:3] = '{14'd1, 14'd19, 14'd361, 14'd6859};

  always #5 clk = ~clk;

  tw_rom_writer #(.LOGQ(14), .LOGN(10), .DELAY_MUL(3), .STAGE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .q(q), .root(root),
    .wen(wen3), .waddr(waddr3), .wdata(wdata3), .wready(wr3),
    .busy(busy3), .done(done3));

  tw_rom_writer #(.LOGQ(14), .LOGN(10), .DELAY_MUL(3), .STAGE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .q(q), .root(root),
    .wen(wen4), .waddr(waddr4), .wdata(wdata4), .wready(wr4),
    .busy(busy4), .done(done4));

  tw_rom_writer #(.LOGQ(14), .LOGN(10), .DELAY_MUL(3), .STAGE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .q(q), .root(root),
    .wen(wen0), .waddr(waddr0), .wdata(wdata0), .wready(wr0),
    .busy(busy0), .done(done0));

  task automatic test_reset;
    #12;
    n_checks++;
    if ({wen3, busy3, done3, waddr3, wdata3} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_stage3: got wen=%b busy=%b done=%b waddr=%0d wdata=%0d, want all 0",
               wen3, busy3, done3, waddr3, wdata3);
    end
    n_checks++;
    if ({wen4, busy4, done4, waddr4, wdata4} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_stage4: got wen=%b busy=%b done=%b waddr=%0d wdata=%0d, want all 0",
               wen4, busy4, done4, waddr4, wdata4);
    end
    n_checks++;
    if ({wen0, busy0, done0, waddr0, wdata0} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_stage0: got wen=%b busy=%b done=%b waddr=%0d wdata=%0d, want all 0",
               wen0, busy0, done0, waddr0, wdata0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({wen3, busy3, done3} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_no_start: got wen=%b busy=%b done=%b, want 000", wen3, busy3, done3);
    end
  endtask

  // Start pulse is high through edge 0; returns #1 into cycle 1.
  task automatic pulse_start3;
    @(posedge clk); #1;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
  endtask

  task automatic test_basic;
    logic ew, eb, ed;
    int   k;
    q = 14'd7681; root = 14'd17; wr3 = 1'b1;
    pulse_start3();
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      ew = (c <= 13) && ((c - 1) % 4 == 0);
      eb = (c <= 13);
      ed = (c == 14);
      k  = (c - 1) / 4;
      n_checks++;
      if ({wen3, busy3, done3} !== {ew, eb, ed}) begin
        n_fail++;
        $display("FAIL basic_ctrl cycle %0d: got wen=%b busy=%b done=%b, want %b %b %b",
                 c, wen3, busy3, done3, ew, eb, ed);
      end
      if (ew) begin
        n_checks++;
        if (waddr3 !== 10'(k) || wdata3 !== tbl17[k]) begin
          n_fail++;
          $display("FAIL basic_write cycle %0d: got (%0d,%0d), want (%0d,%0d)",
                   c, waddr3, wdata3, k, tbl17[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic ew, eb, ed;
    int   k;
    q = 14'd7681; root = 14'd17; wr3 = 1'b1;
    pulse_start3();
    for (int c = 1; c <= 21; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      wr3 = (c >= 5 && c <= 9) ? 1'b0 : 1'b1;
      ew = (c == 1) || (c >= 5 && c <= 10) || (c == 14) || (c == 18);
      eb = (c <= 18);
      ed = (c == 19);
      k  = (c == 1) ? 0 : (c <= 10) ? 1 : (c == 14) ? 2 : 3;
      n_checks++;
      if ({wen3, busy3, done3} !== {ew, eb, ed}) begin
        n_fail++;
        $display("FAIL stall_ctrl cycle %0d: got wen=%b busy=%b done=%b, want %b %b %b",
                 c, wen3, busy3, done3, ew, eb, ed);
      end
      if (ew) begin
        n_checks++;
        if (waddr3 !== 10'(k) || wdata3 !== tbl17[k]) begin
          n_fail++;
          $display("FAIL stall_write cycle %0d: got (%0d,%0d), want (%0d,%0d)",
                   c, waddr3, wdata3, k, tbl17[k]);
        end
      end
    end
    wr3 = 1'b1;
  endtask

  task automatic test_start_ignored;
    logic ew;
    int   k;
    q = 14'd7681; root = 14'd17; wr3 = 1'b1;
    pulse_start3();
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      start3 = (c == 3 || c == 14);
      if (c == 3) root = 14'd3;
      ew = (c <= 13) && ((c - 1) % 4 == 0);
      k  = (c - 1) / 4;
      n_checks++;
      if (wen3 !== ew) begin
        n_fail++;
        $display("FAIL ignore_wen cycle %0d: got %b, want %b", c, wen3, ew);
      end
      if (ew) begin
        n_checks++;
        if (waddr3 !== 10'(k) || wdata3 !== tbl17[k]) begin
          n_fail++;
          $display("FAIL ignore_write cycle %0d: got (%0d,%0d), want (%0d,%0d)",
                   c, waddr3, wdata3, k, tbl17[k]);
        end
      end
    end
    start3 = 1'b0;
    // Fresh start picks up the new root.
    pulse_start3();
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      ew = (c <= 13) && ((c - 1) % 4 == 0);
      k  = (c - 1) / 4;
      if (ew) begin
        n_checks++;
        if (wen3 !== 1'b1 || waddr3 !== 10'(k) || wdata3 !== tbl3[k]) begin
          n_fail++;
          $display("FAIL restart_root3 cycle %0d: got wen=%b (%0d,%0d), want 1 (%0d,%0d)",
                   c, wen3, waddr3, wdata3, k, tbl3[k]);
        end
      end
      if (c == 14) begin
        n_checks++;
        if (done3 !== 1'b1) begin
          n_fail++;
          $display("FAIL restart_done cycle 14: got %b, want 1", done3);
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset;
    q = 14'd7681; root = 14'd17; wr3 = 1'b1;
    pulse_start3();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({wen3, busy3} !== 2'b01) begin
      n_fail++;
      $display("FAIL pre_reset_mul: got wen=%b busy=%b, want 0 1", wen3, busy3);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({wen3, busy3, done3, waddr3, wdata3} !== 27'd0) begin
      n_fail++;
      $display("FAIL async_reset: got wen=%b busy=%b done=%b waddr=%0d wdata=%0d, want all 0",
               wen3, busy3, done3, waddr3, wdata3);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({wen3, busy3, done3} !== 3'b000) begin
        n_fail++;
        $display("FAIL post_reset_idle %0d: got wen=%b busy=%b done=%b, want 000",
                 i, wen3, busy3, done3);
      end
    end
    pulse_start3();
    n_checks++;
    if ({wen3, busy3} !== 2'b11 || waddr3 !== 10'd0 || wdata3 !== 14'd1) begin
      n_fail++;
      $display("FAIL restart_first: got wen=%b busy=%b (%0d,%0d), want 1 1 (0,1)",
               wen3, busy3, waddr3, wdata3);
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (wen3 !== 1'b1 || waddr3 !== 10'd1 || wdata3 !== 14'd17) begin
      n_fail++;
      $display("FAIL restart_second: got wen=%b (%0d,%0d), want 1 (1,17)", wen3, waddr3, wdata3);
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_stage4;
    int idx = 0;
    int last_c = -1;
    bit seen_done = 1'b0;
    q = 14'd7681; root = 14'd17; wr4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int c = 1; c <= 40 && !seen_done; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (wen4) begin
        n_checks++;
        if (idx > 7 || waddr4 !== 10'(idx) || wdata4 !== tbl17[idx & 7]) begin
          n_fail++;
          $display("FAIL stage4_write %0d cycle %0d: got (%0d,%0d), want (%0d,%0d)",
                   idx, c, waddr4, wdata4, idx, tbl17[idx & 7]);
        end
        idx++;
        last_c = c;
      end
      if (done4) begin
        seen_done = 1'b1;
        n_checks++;
        if (c !== 30 || last_c !== 29 || idx !== 8) begin
          n_fail++;
          $display("FAIL stage4_done: got cycle %0d last write %0d count %0d, want 30 29 8",
                   c, last_c, idx);
        end
      end
    end
    if (!seen_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL stage4_timeout: done not seen within 40 cycles, writes %0d, want 8", idx);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_stage0_and_reduce;
    q = 14'd7681; root = 14'd7700; wr0 = 1'b1; wr3 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b1; start3 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start3 = 1'b0;
    n_checks++;
    if ({wen0, busy0, done0} !== 3'b110 || waddr0 !== 10'd0 || wdata0 !== 14'd1) begin
      n_fail++;
      $display("FAIL stage0_write: got wen=%b busy=%b done=%b (%0d,%0d), want 1 1 0 (0,1)",
               wen0, busy0, done0, waddr0, wdata0);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({wen0, busy0, done0} !== 3'b001) begin
      n_fail++;
      $display("FAIL stage0_done: got wen=%b busy=%b done=%b, want 0 0 1", wen0, busy0, done0);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({wen0, busy0, done0} !== 3'b000) begin
      n_fail++;
      $display("FAIL stage0_idle: got wen=%b busy=%b done=%b, want 000", wen0, busy0, done0);
    end
    for (int k = 1; k <= 3; k++) begin
      repeat ((k == 1) ? 2 : 4) @(posedge clk);
      #1;
      n_checks++;
      if (wen3 !== 1'b1 || waddr3 !== 10'(k) || wdata3 !== tbl19[k]) begin
        n_fail++;
        $display("FAIL reduced_root entry %0d: got wen=%b (%0d,%0d), want 1 (%0d,%0d)",
                 k, wen3, waddr3, wdata3, k, tbl19[k]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_start_ignored();
    test_async_reset();
    test_stage4();
    test_stage0_and_reduce();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
